prbs_bit_checker: RTL and testbench

- Serial-bit receive-side checker: samples the single-bit stream leaving a D-flop/serial path (`bit_in`, qualified by `en`) and checks it against a PRBS7 sequence (x^7 + x^6 + 1).
- Self-synchronises by seeding its LFSR from received bits, declares lock, then counts bit errors.
- Used on-chip and in benches as the reading end of stimulus written into flop/serial paths.

---
 rtl/prbs_bit_checker.sv | 140 ++++++++++++++
 tb/tb_prbs_bit_checker.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/prbs_bit_checker.sv
// PRBS7 (x^7 + x^6 + 1) receive-side bit checker: self-seeds, verifies, locks, counts errors.
// Optional PRBS_CHK_BITCNT_EN adds a saturating count of en cycles spent in lock.
module prbs_bit_checker #(
    parameter int unsigned LOCK_CNT   = 8,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_bit_in,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic [ERR_W-1:0] o_err_count
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      o_bit_count
`endif
);

    localparam logic [7:0] LockCntW   = 8'(LOCK_CNT);
    localparam logic [3:0] UnlockCntW = 4'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        StSeed,
        StVerify,
        StLocked
    } state_e;

    state_e           r_state;
    logic [6:0]       r_lfsr;
    logic [2:0]       r_seed_cnt;
    logic [7:0]       r_match_cnt;
    logic [3:0]       r_miss_cnt;
    logic             r_locked;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;

    logic       w_pred;
    logic       w_miss;
    logic [6:0] w_shift_in;
    logic       w_err_inc;
    logic       w_err_sat;

    assign w_pred     = r_lfsr[6] ^ r_lfsr[5];
    assign w_miss     = i_bit_in ^ w_pred;
    assign w_shift_in = {r_lfsr[5:0], i_bit_in};
    assign w_err_inc  = i_en && (r_state == StLocked) && w_miss;
    assign w_err_sat  = &r_err_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StSeed;
            r_lfsr      <= 7'd0;
            r_seed_cnt  <= 3'd0;
            r_match_cnt <= 8'd0;
            r_miss_cnt  <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (i_en) begin
                unique case (r_state)
                    StSeed: begin
                        r_lfsr <= w_shift_in;
                        if (r_seed_cnt == 3'd6) begin
                            r_seed_cnt <= 3'd0;
                            // An all-zero seed would lock onto a dead stream; reseed instead.
                            if (w_shift_in != 7'd0) begin
                                r_state     <= StVerify;
                                r_match_cnt <= 8'd0;
                            end
                        end else begin
                            r_seed_cnt <= r_seed_cnt + 3'd1;
                        end
                    end
                    StVerify: begin
                        r_lfsr <= w_shift_in;
                        if (w_miss) begin
                            r_state    <= StSeed;
                            r_seed_cnt <= 3'd0;
                        end else if (r_match_cnt + 8'd1 == LockCntW) begin
                            r_state    <= StLocked;
                            r_locked   <= 1'b1;
                            r_miss_cnt <= 4'd0;
                        end else begin
                            r_match_cnt <= r_match_cnt + 8'd1;
                        end
                    end
                    StLocked: begin
                        // Free-run on the prediction so isolated errors leave the LFSR intact.
                        r_lfsr <= {r_lfsr[5:0], w_pred};
                        if (w_miss) begin
                            r_err_pulse <= 1'b1;
                            if (r_miss_cnt + 4'd1 == UnlockCntW) begin
                                r_state    <= StSeed;
                                r_locked   <= 1'b0;
                                r_seed_cnt <= 3'd0;
                                r_miss_cnt <= 4'd0;
                            end else begin
                                r_miss_cnt <= r_miss_cnt + 4'd1;
                            end
                        end else begin
                            r_miss_cnt <= 4'd0;
                        end
                    end
                    default: r_state <= StSeed;
                endcase
            end
            if (i_clear) begin
                r_err_count <= '0;
            end else if (w_err_inc && !w_err_sat) begin
                r_err_count <= r_err_count + ERR_W'(1);
            end
        end
    end

`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] r_bit_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_count <= 32'd0;
        end else if (i_clear) begin
            r_bit_count <= 32'd0;
        end else if (i_en && (r_state == StLocked) && !(&r_bit_count)) begin
            r_bit_count <= r_bit_count + 32'd1;
        end
    end

    assign o_bit_count = r_bit_count;
`endif

    assign o_locked    = r_locked;
    assign o_err_pulse = r_err_pulse;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_prbs_bit_checker.sv
// Scoreboard bench for prbs_bit_checker (ERR_W=3): driver queues expected outputs per
// clock, monitor pops and compares after each rising edge.
module tb_prbs_bit_checker;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       bit_in;
    logic       clear;
    logic       locked;
    logic       err_pulse;
    logic [2:0] err_count;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0] bit_count;
`endif

    prbs_bit_checker #(
        .LOCK_CNT  (8),
        .UNLOCK_CNT(4),
        .ERR_W     (3)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_en       (en),
        .i_bit_in   (bit_in),
        .i_clear    (clear),
        .o_locked   (locked),
        .o_err_pulse(err_pulse),
        .o_err_count(err_count)
`ifdef PRBS_CHK_BITCNT_EN
        ,
        .o_bit_count(bit_count)
`endif
    );

    typedef struct packed {
        logic       l;
        logic       p;
        logic [2:0] c;
    } exp_t;

    exp_t  q_exp[$];
    string q_name[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    logic [6:0] g_s;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $fatal(1);
    end

    // Reference PRBS7 generator, output = s[6]^s[5], shifted back in.
    function automatic logic gen_bit();
        logic b;
        b   = g_s[6] ^ g_s[5];
        g_s = {g_s[5:0], b};
        return b;
    endfunction

    task automatic drive(input logic e, input logic b, input logic clr, input logic el,
                         input logic ep, input int ec, input string nm);
        exp_t x;
        @(negedge clk);
        en     = e;
        bit_in = b;
        clear  = clr;
        x.l    = el;
        x.p    = ep;
        x.c    = ec[2:0];
        q_exp.push_back(x);
        q_name.push_back(nm);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    initial begin : monitor
        exp_t  x;
        string nm;
        forever begin
            @(posedge clk);
            #2;
            if (q_exp.size() != 0) begin
                x  = q_exp.pop_front();
                nm = q_name.pop_front();
                n_cmp++;
                if (locked !== x.l || err_pulse !== x.p || err_count !== x.c) begin
                    n_fail++;
                    $display("FAIL %s: got locked=%b pulse=%b cnt=%0d, want locked=%b pulse=%b cnt=%0d",
                             nm, locked, err_pulse, err_count, x.l, x.p, x.c);
                end
            end
        end
    end

    initial begin : stim
        rst_n  = 1'b0;
        en     = 1'b0;
        bit_in = 1'b0;
        clear  = 1'b0;
        g_s    = 7'h7F;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_locked", 32'(locked), 0);
        chk("reset_pulse", 32'(err_pulse), 0);
        chk("reset_count", 32'(err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Lock acquisition: 7 seed + 8 verify bits.
        for (int i = 1; i <= 15; i++) drive(1, gen_bit(), 0, (i == 15), 0, 0, "acq");
        for (int i = 0; i < 5; i++) drive(1, gen_bit(), 0, 1, 0, 0, "locked_clean");

        // Single error.
        drive(1, !gen_bit(), 0, 1, 1, 1, "single_err");
        for (int i = 0; i < 20; i++) drive(1, gen_bit(), 0, 1, 0, 1, "post_err_clean");

        // Loss of lock after 4 consecutive errors, then relock.
        drive(1, gen_bit(), 1, 1, 0, 0, "clear");
        for (int k = 1; k <= 4; k++) drive(1, !gen_bit(), 0, (k < 4), 1, k, "burst_err");
        for (int i = 1; i <= 15; i++) drive(1, gen_bit(), 0, (i == 15), 0, 4, "relock");

        // Saturation at 7 with ERR_W=3, then clear, then clear colliding with an error.
        drive(1, gen_bit(), 1, 1, 0, 0, "clear_pre_sat");
        for (int k = 1; k <= 10; k++) begin
            drive(1, !gen_bit(), 0, 1, 1, (k < 7) ? k : 7, "sat_err");
            drive(1, gen_bit(), 0, 1, 0, (k < 7) ? k : 7, "sat_gap");
            drive(1, gen_bit(), 0, 1, 0, (k < 7) ? k : 7, "sat_gap");
        end
        drive(1, gen_bit(), 1, 1, 0, 0, "clear_sat");
        drive(1, !gen_bit(), 1, 1, 1, 0, "clear_vs_err");
        drive(1, gen_bit(), 0, 1, 0, 0, "after_clr_err");

        // Stall right after an error: pulse drops, nothing else moves, stream resumes clean.
        drive(1, !gen_bit(), 0, 1, 1, 1, "pre_stall_err");
        for (int i = 0; i < 3; i++) drive(0, i[0], 0, 1, 0, 1, "stall");
        for (int i = 0; i < 5; i++) drive(1, gen_bit(), 0, 1, 0, 1, "resume");

        // Reach err_count=2 with the pulse high, then reset asynchronously mid-cycle.
        drive(1, gen_bit(), 0, 1, 0, 1, "pre_rst_clean");
        drive(1, !gen_bit(), 0, 1, 1, 2, "pre_rst_err");
        @(negedge clk);
        en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", 32'(locked), 0);
        chk("async_rst_pulse", 32'(err_pulse), 0);
        chk("async_rst_count", 32'(err_count), 0);
`ifdef PRBS_CHK_BITCNT_EN
        chk("async_rst_bitcnt", bit_count, 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero stream never locks; 21 zeros leave the seeder at a 7-bit boundary.
        for (int i = 0; i < 21; i++) drive(1, 0, 0, 0, 0, 0, "all_zero");
        for (int i = 1; i <= 15; i++) drive(1, gen_bit(), 0, (i == 15), 0, 0, "fresh_lock");
        for (int i = 0; i < 3; i++) drive(1, gen_bit(), 0, 1, 0, 0, "fresh_clean");
        @(negedge clk);
        en = 1'b0;

        for (int i = 0; i < 10 && q_exp.size() != 0; i++) @(posedge clk);
        #3;
        if (q_exp.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q_exp.size());
        end
`ifdef PRBS_CHK_BITCNT_EN
        chk("bit_count", bit_count, 3);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
